// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite initiator: FSM states, default widths,
// and command/response bundles used by the master and its bench.
package axi_lite_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
        logic [DATA_W_DEF/8-1:0] wstrb;
    } cmd_t;

    typedef struct packed {
        logic                  write;
        logic [DATA_W_DEF-1:0] rdata;
    } rsp_t;

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: one command in, one single-beat AXI4-Lite
// write or read out, one response back.  One transaction in flight.
// Ports:
//   ACLK/ARESETn          clock, async active-low reset
//   cmd_*                 command handshake (valid/ready, write, addr,
//                         wdata, wstrb)
//   rsp_*                 response handshake (valid/ready, write, rdata)
//   AW*/W*/B*/AR*/R*      AXI4-Lite master channels (no RESP)
//   wr_cnt/rd_cnt         free-running completion counters (wrap)
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int CNT_WIDTH  = CNT_W_DEF
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic                    BVALID,
    output logic                    BREADY,
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic                    RVALID,
    output logic                    RREADY,
    output logic [CNT_WIDTH-1:0]    wr_cnt,
    output logic [CNT_WIDTH-1:0]    rd_cnt
);

    localparam int SW = DATA_WIDTH / 8;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE =
        {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state,     w_state;
    logic                  r_awvalid,   w_awvalid;
    logic                  r_wvalid,    w_wvalid;
    logic                  r_bready,    w_bready;
    logic                  r_arvalid,   w_arvalid;
    logic                  r_rready,    w_rready;
    logic                  r_aw_done,   w_aw_done;
    logic                  r_w_done,    w_w_done;
    logic [ADDR_WIDTH-1:0] r_addr,      w_addr;
    logic [DATA_WIDTH-1:0] r_wdata,     w_wdata;
    logic [SW-1:0]         r_wstrb,     w_wstrb;
    logic                  r_rsp_valid, w_rsp_valid;
    logic                  r_rsp_write, w_rsp_write;
    logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata;
    logic [CNT_WIDTH-1:0]  r_wr_cnt,    w_wr_cnt;
    logic [CNT_WIDTH-1:0]  r_rd_cnt,    w_rd_cnt;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state     <= IDLE;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
        end else begin
            r_state     <= w_state;
            r_awvalid   <= w_awvalid;
            r_wvalid    <= w_wvalid;
            r_bready    <= w_bready;
            r_arvalid   <= w_arvalid;
            r_rready    <= w_rready;
            r_aw_done   <= w_aw_done;
            r_w_done    <= w_w_done;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_wstrb     <= w_wstrb;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_write <= w_rsp_write;
            r_rsp_rdata <= w_rsp_rdata;
            r_wr_cnt    <= w_wr_cnt;
            r_rd_cnt    <= w_rd_cnt;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_awvalid   = r_awvalid;
        w_wvalid    = r_wvalid;
        w_bready    = r_bready;
        w_arvalid   = r_arvalid;
        w_rready    = r_rready;
        w_aw_done   = r_aw_done;
        w_w_done    = r_w_done;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_wstrb     = r_wstrb;
        w_rsp_valid = r_rsp_valid;
        w_rsp_write = r_rsp_write;
        w_rsp_rdata = r_rsp_rdata;
        w_wr_cnt    = r_wr_cnt;
        w_rd_cnt    = r_rd_cnt;
        unique case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_addr  = cmd_addr;
                    w_wdata = cmd_wdata;
                    w_wstrb = cmd_wstrb;
                    if (cmd_write) begin
                        w_state   = WR_REQ;
                        w_awvalid = 1'b1;
                        w_wvalid  = 1'b1;
                        w_aw_done = 1'b0;
                        w_w_done  = 1'b0;
                    end else begin
                        w_state   = RD_REQ;
                        w_arvalid = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                // each channel retires on its own handshake
                if (r_awvalid && AWREADY) begin
                    w_awvalid = 1'b0;
                    w_aw_done = 1'b1;
                end
                if (r_wvalid && WREADY) begin
                    w_wvalid = 1'b0;
                    w_w_done = 1'b1;
                end
                // B is opened only once both flags are registered
                if (r_aw_done && r_w_done) begin
                    w_state  = WR_RESP;
                    w_bready = 1'b1;
                end
            end
            WR_RESP: begin
                if (BVALID) begin
                    w_state     = RSP;
                    w_bready    = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_rsp_write = 1'b1;
                    w_rsp_rdata = '0;
                    w_wr_cnt    = r_wr_cnt + CNT_ONE;
                end
            end
            RD_REQ: begin
                if (ARREADY) begin
                    w_state   = RD_DATA;
                    w_arvalid = 1'b0;
                    w_rready  = 1'b1;
                end
            end
            RD_DATA: begin
                if (RVALID) begin
                    w_state     = RSP;
                    w_rready    = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_rsp_write = 1'b0;
                    w_rsp_rdata = RDATA;
                    w_rd_cnt    = r_rd_cnt + CNT_ONE;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    w_state     = IDLE;
                    w_rsp_valid = 1'b0;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign cmd_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_rdata = r_rsp_rdata;
    assign AWADDR    = r_addr;
    assign AWVALID   = r_awvalid;
    assign WDATA     = r_wdata;
    assign WSTRB     = r_wstrb;
    assign WVALID    = r_wvalid;
    assign BREADY    = r_bready;
    assign ARADDR    = r_addr;
    assign ARVALID   = r_arvalid;
    assign RREADY    = r_rready;
    assign wr_cnt    = r_wr_cnt;
    assign rd_cnt    = r_rd_cnt;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: directed vector table driving a
// delay-programmable AXI4-Lite slave model, plus reset/wrap sequences.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] AWADDR;
    logic          AWVALID;
    logic          AWREADY = 1'b0;
    logic [DW-1:0] WDATA;
    logic [3:0]    WSTRB;
    logic          WVALID;
    logic          WREADY = 1'b0;
    logic          BVALID = 1'b0;
    logic          BREADY;
    logic [AW-1:0] ARADDR;
    logic          ARVALID;
    logic          ARREADY = 1'b0;
    logic [DW-1:0] RDATA = '0;
    logic          RVALID = 1'b0;
    logic          RREADY;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;

    axi_lite_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .AWADDR   (AWADDR),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .ARADDR   (ARADDR),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .RDATA    (RDATA),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .wr_cnt   (wr_cnt),
        .rd_cnt   (rd_cnt)
    );

    always #5 ACLK = ~ACLK;

    int errors = 0;
    int checks = 0;
    int viol = 0;

    // slave delay knobs (READY/VALID lag in cycles)
    int aw_dly = 0;
    int w_dly = 0;
    int b_dly = 0;
    int ar_dly = 0;
    int r_dly = 0;
    logic [DW-1:0] r_val = '0;

    // handshake tracking, owned by the posedge monitor
    logic          got_aw = 1'b0;
    logic          got_w = 1'b0;
    logic          got_ar = 1'b0;
    logic [AW-1:0] cap_awaddr = '0;
    logic [DW-1:0] cap_wdata = '0;
    logic [3:0]    cap_wstrb = '0;
    logic [AW-1:0] cap_araddr = '0;
    logic          p_aw = 1'b0;
    logic          p_w = 1'b0;
    logic          p_ar = 1'b0;
    logic [AW-1:0] p_awaddr = '0;
    logic [DW-1:0] p_wdata = '0;
    logic [AW-1:0] p_araddr = '0;

    always @(posedge ACLK) begin
        if (!ARESETn) begin
            got_aw = 1'b0;
            got_w  = 1'b0;
            got_ar = 1'b0;
            p_aw   = 1'b0;
            p_w    = 1'b0;
            p_ar   = 1'b0;
        end else begin
            if (p_aw && (!AWVALID || AWADDR != p_awaddr)) viol++;
            if (p_w && (!WVALID || WDATA != p_wdata)) viol++;
            if (p_ar && (!ARVALID || ARADDR != p_araddr)) viol++;
            if (BREADY && !(got_aw && got_w)) viol++;
            if (RREADY && !got_ar) viol++;
            if (ARVALID && (AWVALID || WVALID)) viol++;
            p_aw     = AWVALID && !AWREADY;
            p_w      = WVALID && !WREADY;
            p_ar     = ARVALID && !ARREADY;
            p_awaddr = AWADDR;
            p_wdata  = WDATA;
            p_araddr = ARADDR;
            if (AWVALID && AWREADY) begin
                got_aw = 1'b1;
                cap_awaddr = AWADDR;
            end
            if (WVALID && WREADY) begin
                got_w = 1'b1;
                cap_wdata = WDATA;
                cap_wstrb = WSTRB;
            end
            if (ARVALID && ARREADY) begin
                got_ar = 1'b1;
                cap_araddr = ARADDR;
            end
            if (BVALID && BREADY) begin
                got_aw = 1'b0;
                got_w  = 1'b0;
            end
            if (RVALID && RREADY) got_ar = 1'b0;
        end
    end

    int aw_c = 0;
    int w_c = 0;
    int b_c = 0;
    int ar_c = 0;
    int r_c = 0;

    // slave drive side, updated away from the active edge
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            AWREADY = 1'b0;
            WREADY  = 1'b0;
            ARREADY = 1'b0;
            BVALID  = 1'b0;
            RVALID  = 1'b0;
            aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        end else begin
            if (AWVALID) begin
                AWREADY = (aw_c >= aw_dly);
                aw_c++;
            end else begin
                AWREADY = 1'b0;
                aw_c = 0;
            end
            if (WVALID) begin
                WREADY = (w_c >= w_dly);
                w_c++;
            end else begin
                WREADY = 1'b0;
                w_c = 0;
            end
            if (ARVALID) begin
                ARREADY = (ar_c >= ar_dly);
                ar_c++;
            end else begin
                ARREADY = 1'b0;
                ar_c = 0;
            end
            if (!(got_aw && got_w)) begin
                BVALID = 1'b0;
                b_c = 0;
            end else if (!BVALID) begin
                if (b_c >= b_dly) BVALID = 1'b1;
                else b_c++;
            end
            if (!got_ar) begin
                RVALID = 1'b0;
                r_c = 0;
            end else if (!RVALID) begin
                if (r_c >= r_dly) begin
                    RVALID = 1'b1;
                    RDATA  = r_val;
                end else begin
                    r_c++;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          awd, wd, bd, ard, rd;
        logic [31:0] rdata;
        int          hold;
        int          lat;
    } vec_t;

    logic [CW-1:0] exp_wr = '0;
    logic [CW-1:0] exp_rd = '0;

    // one complete command/response exchange; starts and ends at negedge
    task automatic do_txn(input vec_t v);
        int n;
        logic [31:0] exp_data;
        aw_dly = v.awd; w_dly = v.wd; b_dly = v.bd;
        ar_dly = v.ard; r_dly = v.rd; r_val = v.rdata;
        exp_data = v.wr ? 32'h0 : v.rdata;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_wstrb = v.wstrb;
        @(posedge ACLK);
        @(negedge ACLK);
        cmd_valid = 1'b0;
        if (v.wr)
            chk("req_valid", {61'd0, AWVALID, WVALID, ARVALID}, 64'd6);
        else
            chk("req_valid", {61'd0, AWVALID, WVALID, ARVALID}, 64'd1);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        chk("rsp_seen", {63'd0, rsp_valid}, 64'd1);
        if (v.lat >= 0) chk("latency", 64'(n), 64'(v.lat));
        chk("rsp_write", {63'd0, rsp_write}, {63'd0, v.wr});
        chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, exp_data});
        for (int h = 0; h < v.hold; h++) begin
            @(negedge ACLK);
            chk("hold_ctl", {60'd0, rsp_valid, cmd_ready, AWVALID,
                ARVALID}, 64'd8);
            chk("hold_data", {31'd0, rsp_write, rsp_rdata},
                {31'd0, v.wr, exp_data});
        end
        rsp_ready = 1'b1;
        @(negedge ACLK);
        rsp_ready = 1'b0;
        chk("rsp_done", {62'd0, rsp_valid, cmd_ready}, 64'd1);
        if (v.wr) begin
            exp_wr = exp_wr + 1'b1;
            chk("awaddr_sb", {32'd0, cap_awaddr}, {32'd0, v.addr});
            chk("wdata_sb", {32'd0, cap_wdata}, {32'd0, v.wdata});
            chk("wstrb_sb", {60'd0, cap_wstrb}, {60'd0, v.wstrb});
        end else begin
            exp_rd = exp_rd + 1'b1;
            chk("araddr_sb", {32'd0, cap_araddr}, {32'd0, v.addr});
        end
        chk("wr_cnt", {60'd0, wr_cnt}, {60'd0, exp_wr});
        chk("rd_cnt", {60'd0, rd_cnt}, {60'd0, exp_rd});
    endtask

    task automatic pulse_reset();
        @(negedge ACLK);
        ARESETn = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        exp_wr = '0;
        exp_rd = '0;
    endtask

    vec_t vt[7];
    vec_t rv;

    initial begin
        // wr addr wdata strb awd wd bd ard rd rdata hold lat
        vt[0] = '{1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0,
                  32'h0, 0, 3};
        vt[1] = '{1, 32'h18, 32'hA5A50001, 4'h3, 3, 0, 0, 0, 0,
                  32'h0, 0, 6};
        vt[2] = '{0, 32'h14, 32'h0, 4'h0, 0, 0, 0, 2, 2,
                  32'hCAFEF00D, 0, 6};
        vt[3] = '{0, 32'h100, 32'h0, 4'h0, 0, 0, 0, 0, 0,
                  32'h0BADC0DE, 0, 2};
        vt[4] = '{1, 32'h24, 32'h55AA55AA, 4'h5, 0, 2, 2, 0, 0,
                  32'h0, 0, 6};
        vt[5] = '{1, 32'h30, 32'h11223344, 4'hF, 0, 0, 0, 0, 0,
                  32'h0, 5, 3};
        vt[6] = '{0, 32'h34, 32'h0, 4'h0, 0, 0, 0, 0, 1,
                  32'h87654321, 2, 3};

        ARESETn = 1'b0;
        repeat (2) @(negedge ACLK);
        chk("rst_valids", {59'd0, AWVALID, WVALID, ARVALID, BREADY,
            RREADY}, 64'd0);
        chk("rst_rsp", {31'd0, rsp_valid, rsp_rdata}, 64'd0);
        chk("rst_cnt", {56'd0, wr_cnt, rd_cnt}, 64'd0);
        chk("rst_addr", {32'd0, AWADDR}, 64'd0);
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);

        for (int i = 0; i < 7; i++) do_txn(vt[i]);

        // write stalled on AW, W retires first
        aw_dly = 3; w_dly = 0; b_dly = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1;
        cmd_addr = 32'h40; cmd_wdata = 32'hFEEDFACE; cmd_wstrb = 4'hF;
        @(posedge ACLK);
        @(negedge ACLK);
        cmd_valid = 1'b0;
        @(negedge ACLK);
        chk("w_first", {60'd0, AWVALID, WVALID, BREADY, RREADY}, 64'd8);
        chk("aw_stable", {32'd0, AWADDR}, 64'h40);
        repeat (6) @(negedge ACLK);
        chk("w_first_rsp", {62'd0, rsp_valid, rsp_write}, 64'd3);
        rsp_ready = 1'b1;
        @(negedge ACLK);
        rsp_ready = 1'b0;
        exp_wr = exp_wr + 1'b1;
        chk("w_first_cnt", {60'd0, wr_cnt}, {60'd0, exp_wr});

        // reset while AWVALID is waiting
        aw_dly = 20;
        cmd_valid = 1'b1; cmd_write = 1'b1;
        cmd_addr = 32'h50; cmd_wdata = 32'h0; cmd_wstrb = 4'hF;
        @(posedge ACLK);
        @(negedge ACLK);
        cmd_valid = 1'b0;
        @(negedge ACLK);
        chk("pre_rst_aw", {63'd0, AWVALID}, 64'd1);
        #2 ARESETn = 1'b0;
        #1;
        chk("async_rst", {61'd0, AWVALID, WVALID, BREADY}, 64'd0);
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        exp_wr = '0;
        exp_rd = '0;
        @(negedge ACLK);
        chk("post_rst", {60'd0, cmd_ready, rsp_valid, wr_cnt[0],
            AWVALID}, 64'd8);
        rv = '{1, 32'h20, 32'h12345678, 4'hF, 0, 0, 0, 0, 0,
               32'h0, 0, 3};
        do_txn(rv);

        // counter wrap over 17 writes with random slave delays
        pulse_reset();
        @(negedge ACLK);
        for (int k = 0; k < 17; k++) begin
            rv.wr    = 1'b1;
            rv.addr  = {$urandom_range(0, 255), 2'b00};
            rv.wdata = $urandom;
            rv.wstrb = 4'($urandom_range(1, 15));
            rv.awd   = $urandom_range(0, 3);
            rv.wd    = $urandom_range(0, 3);
            rv.bd    = $urandom_range(0, 3);
            rv.hold  = $urandom_range(0, 2);
            rv.lat   = -1;
            do_txn(rv);
        end
        chk("wrap", {60'd0, wr_cnt}, 64'd1);

        chk("protocol", 64'(viol), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
